// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, baud-select encodings and
// frame-format defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    typedef enum logic [1:0] {
        Baud4800  = 2'b00,
        Baud9600  = 2'b01,
        Baud19200 = 2'b10,
        Baud38400 = 2'b11
    } baud_sel_t;

    localparam int unsigned DefDataBits  = 8;
    localparam int unsigned DefParityEn  = 0;
    localparam int unsigned DefParityOdd = 0;
    localparam int unsigned DefStopBits  = 1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel byte handshake between the upstream producer and the TX serializer.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-byte holding register feeding a start/data/parity/stop
// frame shifter that advances once per baud tick.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DefDataBits,
    parameter int unsigned PARITY_EN  = DefParityEn,
    parameter int unsigned PARITY_ODD = DefParityOdd,
    parameter int unsigned STOP_BITS  = DefStopBits
) (
    input  logic                 clk_1,
    input  logic                 reset,
    input  logic                 baud_tick,
    uart_tx_serializer_if.slave  tx_if,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned     CntW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CntW-1:0] LastBit  = CntW'(DATA_BITS - 1);
    localparam logic            StopLast = 1'(STOP_BITS - 1);
    localparam logic            ParEn    = (PARITY_EN != 0);
    localparam logic            ParOdd   = (PARITY_ODD != 0);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 hold_full_q, hold_full_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 accept;
    logic                 load;

    assign tx_if.tx_ready = !hold_full_q;
    assign accept         = tx_if.tx_valid && !hold_full_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;
        load       = 1'b0;

        if (baud_tick) begin
            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end
                end
                StStart: begin
                    state_d   = StData;
                    tx_out_d  = shift_q[0];
                    bit_cnt_d = '0;
                end
                StData: begin
                    if (bit_cnt_q == LastBit) begin
                        if (ParEn) begin
                            state_d  = StParity;
                            tx_out_d = parity_q;
                        end else begin
                            state_d    = StStop;
                            tx_out_d   = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_out_d  = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    state_d    = StStop;
                    tx_out_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                StStop: begin
                    if (stop_cnt_q == StopLast) begin
                        tx_done_d = 1'b1;
                        // A waiting byte starts immediately, with no idle bit in between.
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d  = StIdle;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    tx_out_d = 1'b1;
                end
            endcase
        end

        if (load) begin
            state_d  = StStart;
            tx_out_d = 1'b0;
            shift_d  = hold_q;
            parity_d = (^hold_q) ^ ParOdd;
        end

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = tx_if.tx_data;
            hold_full_d = 1'b1;
        end

        tx_busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_1) begin
        if (!reset) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            parity_q    <= 1'b0;
            tx_out_q    <= 1'b1;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            parity_q    <= parity_d;
            tx_out_q    <= tx_out_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx_out  = tx_out_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
